// File: rtl/ps2_hex_entry_pkg.sv
// Shared scan-code constants, receiver state encoding and the hex-key lookup
// used by the PS/2 hex-entry front end.
package ps2_hex_entry_pkg;

  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_BKSP  = 8'h66;
  localparam logic [7:0] CODE_ESC   = 8'h76;

  localparam logic [7:0] CODE_HEX0 = 8'h45;
  localparam logic [7:0] CODE_HEX1 = 8'h16;
  localparam logic [7:0] CODE_HEX2 = 8'h1E;
  localparam logic [7:0] CODE_HEX3 = 8'h26;
  localparam logic [7:0] CODE_HEX4 = 8'h25;
  localparam logic [7:0] CODE_HEX5 = 8'h2E;
  localparam logic [7:0] CODE_HEX6 = 8'h36;
  localparam logic [7:0] CODE_HEX7 = 8'h3D;
  localparam logic [7:0] CODE_HEX8 = 8'h3E;
  localparam logic [7:0] CODE_HEX9 = 8'h46;
  localparam logic [7:0] CODE_HEXA = 8'h1C;
  localparam logic [7:0] CODE_HEXB = 8'h32;
  localparam logic [7:0] CODE_HEXC = 8'h21;
  localparam logic [7:0] CODE_HEXD = 8'h23;
  localparam logic [7:0] CODE_HEXE = 8'h24;
  localparam logic [7:0] CODE_HEXF = 8'h2B;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rxState_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] nibble;
  } hexKey_t;

  function automatic hexKey_t decodeHex(input logic [7:0] code);
    hexKey_t key;
    key = '0;
    key.valid = 1'b1;
    case (code)
      CODE_HEX0: key.nibble = 4'h0;
      CODE_HEX1: key.nibble = 4'h1;
      CODE_HEX2: key.nibble = 4'h2;
      CODE_HEX3: key.nibble = 4'h3;
      CODE_HEX4: key.nibble = 4'h4;
      CODE_HEX5: key.nibble = 4'h5;
      CODE_HEX6: key.nibble = 4'h6;
      CODE_HEX7: key.nibble = 4'h7;
      CODE_HEX8: key.nibble = 4'h8;
      CODE_HEX9: key.nibble = 4'h9;
      CODE_HEXA: key.nibble = 4'hA;
      CODE_HEXB: key.nibble = 4'hB;
      CODE_HEXC: key.nibble = 4'hC;
      CODE_HEXD: key.nibble = 4'hD;
      CODE_HEXE: key.nibble = 4'hE;
      CODE_HEXF: key.nibble = 4'hF;
      default:   key.valid  = 1'b0;
    endcase
    return key;
  endfunction

endpackage

// File: rtl/ps2_hex_entry_if.sv
// Keyboard-side inputs and display-side outputs of the hex-entry block.
interface ps2_hex_entry_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] data_out;
  logic [7:0]  scan_code;
  logic        key_valid;
  logic        frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  data_out, scan_code, key_valid, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output data_out, scan_code, key_valid, frame_err
  );
endinterface

// File: rtl/ps2_hex_entry_rx.sv
// PS/2 byte receiver: synchronizers, clock glitch filter, fall-edge detect,
// 11-bit frame FSM with odd-parity/stop checking and an inactivity timeout.
module ps2_hex_entry_rx
  import ps2_hex_entry_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_ps2Clk,
  input  logic       i_ps2Data,
  output logic       o_codeStrobe,
  output logic [7:0] o_code,
  output logic       o_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    r_clkSync;
  logic [1:0]    r_dataSync;
  logic [FW-1:0] r_filtCnt;
  logic          r_filtClk;
  logic          r_filtClkD;
  logic [2:0]    r_bitCnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic [TW-1:0] r_toCnt;
  logic          r_codeStrobe;
  logic [7:0]    r_code;
  logic          r_err;
  rxState_t      r_state;
  rxState_t      w_nextState;
  logic          w_fall;
  logic          w_sampleData;
  logic          w_timeout;
  logic          w_frameGood;

  // Synchronizers reset to the idle-high bus level so release never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clkSync  <= 2'b11;
      r_dataSync <= 2'b11;
    end else begin
      r_clkSync  <= {r_clkSync[0], i_ps2Clk};
      r_dataSync <= {r_dataSync[0], i_ps2Data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filtCnt  <= '0;
      r_filtClk  <= 1'b1;
      r_filtClkD <= 1'b1;
    end else begin
      r_filtClkD <= r_filtClk;
      if (r_clkSync[1] == r_filtClk) begin
        r_filtCnt <= '0;
      end else if (r_filtCnt == FW'(FILTER_LEN - 1)) begin
        r_filtClk <= r_clkSync[1];
        r_filtCnt <= '0;
      end else begin
        r_filtCnt <= r_filtCnt + 1'b1;
      end
    end
  end

  assign w_fall       = r_filtClkD & ~r_filtClk;
  assign w_sampleData = r_dataSync[1];
  assign w_frameGood  = (^r_shift ^ r_parity) & w_sampleData;
  assign w_timeout    = (r_state != RX_IDLE) && !w_fall &&
                        (r_toCnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_toCnt <= '0;
    end else if (r_state == RX_IDLE || w_fall) begin
      r_toCnt <= '0;
    end else begin
      r_toCnt <= r_toCnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (w_timeout) begin
      w_nextState = RX_IDLE;
    end else if (w_fall) begin
      case (r_state)
        RX_IDLE:   if (!w_sampleData) w_nextState = RX_DATA;
        RX_DATA:   if (r_bitCnt == 3'd7) w_nextState = RX_PARITY;
        RX_PARITY: w_nextState = RX_STOP;
        RX_STOP:   w_nextState = RX_IDLE;
        default:   w_nextState = RX_IDLE;
      endcase
    end
  end

  // Bits arrive LSB first, so the shift register fills from the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bitCnt     <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_codeStrobe <= 1'b0;
      r_code       <= '0;
      r_err        <= 1'b0;
    end else begin
      r_codeStrobe <= 1'b0;
      r_err        <= 1'b0;
      if (w_timeout) begin
        r_err <= 1'b1;
      end else if (w_fall) begin
        case (r_state)
          RX_IDLE:   r_bitCnt <= '0;
          RX_DATA: begin
            r_shift  <= {w_sampleData, r_shift[7:1]};
            r_bitCnt <= r_bitCnt + 1'b1;
          end
          RX_PARITY: r_parity <= w_sampleData;
          RX_STOP: begin
            if (w_frameGood) begin
              r_codeStrobe <= 1'b1;
              r_code       <= r_shift;
            end else begin
              r_err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_codeStrobe = r_codeStrobe;
  assign o_code       = r_code;
  assign o_err        = r_err;

endmodule

// File: rtl/ps2_hex_entry.sv
// Calculator-style hex entry: decodes PS/2 make codes into a 4-digit value
// that shifts new digits in from the right, with backspace and Esc clear.
module ps2_hex_entry
  import ps2_hex_entry_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic             clk,
  input logic             rst_n,
  ps2_hex_entry_if.slave  bus
);

  logic        w_codeStrobe;
  logic [7:0]  w_code;
  logic        w_err;
  hexKey_t     w_hexKey;
  logic        r_brk;
  logic        r_ext;
  logic [15:0] r_dataOut;
  logic        r_keyValid;

  ps2_hex_entry_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_ps2Clk     (bus.ps2_clk),
    .i_ps2Data    (bus.ps2_data),
    .o_codeStrobe (w_codeStrobe),
    .o_code       (w_code),
    .o_err        (w_err)
  );

  assign w_hexKey = decodeHex(w_code);

  // A break or extended prefix swallows exactly one following byte; E0 F0 xx
  // sets both flags and still swallows only the xx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_brk      <= 1'b0;
      r_ext      <= 1'b0;
      r_dataOut  <= '0;
      r_keyValid <= 1'b0;
    end else begin
      r_keyValid <= 1'b0;
      if (w_err) begin
        r_brk <= 1'b0;
        r_ext <= 1'b0;
      end else if (w_codeStrobe) begin
        if (w_code == CODE_BREAK) begin
          r_brk <= 1'b1;
        end else if (w_code == CODE_EXT) begin
          r_ext <= 1'b1;
        end else if (r_brk || r_ext) begin
          r_brk <= 1'b0;
          r_ext <= 1'b0;
        end else if (w_hexKey.valid) begin
          r_dataOut  <= {r_dataOut[11:0], w_hexKey.nibble};
          r_keyValid <= 1'b1;
        end else if (w_code == CODE_BKSP) begin
          r_dataOut  <= {4'h0, r_dataOut[15:4]};
          r_keyValid <= 1'b1;
        end else if (w_code == CODE_ESC) begin
          r_dataOut  <= '0;
          r_keyValid <= 1'b1;
        end
      end
    end
  end

  assign bus.data_out  = r_dataOut;
  assign bus.scan_code = w_code;
  assign bus.key_valid = r_keyValid;
  assign bus.frame_err = w_err;

endmodule

// File: tb/tb_ps2_hex_entry.sv
// Self-checking bench for ps2_hex_entry: frame table plus timeout, glitch and
// mid-frame reset sequences, with a key_valid scoreboard.
module tb_ps2_hex_entry;

  localparam int TO   = 2000;
  localparam int HALF = 40;

  typedef struct {
    logic [7:0]  code;
    bit          badParity;
    bit          badStop;
    bit          expKey;
    logic [15:0] expData;
    logic [7:0]  expScan;
    int          expErr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_hex_entry_if bus();

  ps2_hex_entry #(
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          lastFall = -100;
  int          errPulses = 0;
  int          e0;
  logic [15:0] expQ[$];
  logic [15:0] sbExp;
  vec_t        vecs[15];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives nBits of an 11-bit frame; data changes mid-way through the high phase.
  task automatic applyStimulus(input logic [7:0] code, input bit badParity, input bit badStop,
                               input bit glitch, input int nBits);
    logic [10:0] bits;
    bits = {~badStop, (~^code) ^ badParity, code, 1'b0};
    for (int i = 0; i < nBits; i++) begin
      bus.ps2_data = bits[i];
      waitCycles(HALF / 2);
      if (glitch) begin
        bus.ps2_clk = 1'b0;
        waitCycles(3);
        bus.ps2_clk = 1'b1;
        waitCycles(HALF / 2 - 3);
      end else begin
        waitCycles(HALF / 2);
      end
      bus.ps2_clk = 1'b0;
      waitCycles(HALF);
      bus.ps2_clk = 1'b1;
    end
    if (nBits == 11) begin
      bus.ps2_data = 1'b1;
      waitCycles(60);
    end
  endtask

  always @(posedge clk) cycle++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (dut.u_rx.w_fall) lastFall = cycle;
      if (bus.frame_err) errPulses++;
      if (bus.key_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected key_valid", bus.key_valid, 0);
        end else begin
          sbExp = expQ.pop_front();
          checkOutput("scoreboard data_out", bus.data_out, sbExp);
          checkOutput("key_valid latency", cycle - lastFall, 2);
        end
      end
    end
  end

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst_n = 1'b0;
    waitCycles(5);
    checkOutput("reset data_out", bus.data_out, 16'h0000);
    checkOutput("reset scan_code", bus.scan_code, 8'h00);
    checkOutput("reset key_valid", bus.key_valid, 0);
    checkOutput("reset frame_err", bus.frame_err, 0);
    rst_n = 1'b1;
    waitCycles(20);

    vecs[0]  = '{8'h16, 0, 0, 1, 16'h0001, 8'h16, 0};
    vecs[1]  = '{8'h1E, 0, 0, 1, 16'h0012, 8'h1E, 0};
    vecs[2]  = '{8'h26, 0, 0, 1, 16'h0123, 8'h26, 0};
    vecs[3]  = '{8'h25, 0, 0, 1, 16'h1234, 8'h25, 0};
    vecs[4]  = '{8'h1C, 0, 0, 1, 16'h234A, 8'h1C, 0};
    vecs[5]  = '{8'hF0, 0, 0, 0, 16'h234A, 8'hF0, 0};
    vecs[6]  = '{8'h1C, 0, 0, 0, 16'h234A, 8'h1C, 0};
    vecs[7]  = '{8'h66, 0, 0, 1, 16'h0234, 8'h66, 0};
    vecs[8]  = '{8'hE0, 0, 0, 0, 16'h0234, 8'hE0, 0};
    vecs[9]  = '{8'h71, 0, 0, 0, 16'h0234, 8'h71, 0};
    vecs[10] = '{8'h76, 0, 0, 1, 16'h0000, 8'h76, 0};
    vecs[11] = '{8'h3D, 0, 0, 1, 16'h0007, 8'h3D, 0};
    vecs[12] = '{8'h3D, 0, 0, 1, 16'h0077, 8'h3D, 0};
    vecs[13] = '{8'h45, 1, 0, 0, 16'h0077, 8'h3D, 1};
    vecs[14] = '{8'h45, 0, 1, 0, 16'h0077, 8'h3D, 1};

    for (int i = 0; i < 15; i++) begin
      e0 = errPulses;
      if (vecs[i].expKey) expQ.push_back(vecs[i].expData);
      applyStimulus(vecs[i].code, vecs[i].badParity, vecs[i].badStop, 1'b0, 11);
      checkOutput($sformatf("vec%0d data_out", i), bus.data_out, vecs[i].expData);
      checkOutput($sformatf("vec%0d scan_code", i), bus.scan_code, vecs[i].expScan);
      checkOutput($sformatf("vec%0d frame_err count", i), errPulses - e0, vecs[i].expErr);
    end

    // Partial frame then silence: the timeout must abort it exactly once.
    e0 = errPulses;
    applyStimulus(8'h16, 1'b0, 1'b0, 1'b0, 4);
    bus.ps2_data = 1'b1;
    waitCycles(TO + 10);
    checkOutput("timeout frame_err count", errPulses - e0, 1);
    checkOutput("timeout data_out", bus.data_out, 16'h0077);
    expQ.push_back(16'h0771);
    applyStimulus(8'h16, 1'b0, 1'b0, 1'b0, 11);
    checkOutput("after timeout data_out", bus.data_out, 16'h0771);

    // Short clock glitches inside each high phase must not add bits.
    e0 = errPulses;
    expQ.push_back(16'h7712);
    applyStimulus(8'h1E, 1'b0, 1'b0, 1'b1, 11);
    checkOutput("glitch data_out", bus.data_out, 16'h7712);
    checkOutput("glitch scan_code", bus.scan_code, 8'h1E);
    checkOutput("glitch frame_err count", errPulses - e0, 0);

    // Reset in the middle of a frame drops it silently.
    applyStimulus(8'h2E, 1'b0, 1'b0, 1'b0, 5);
    rst_n = 1'b0;
    waitCycles(3);
    checkOutput("midreset data_out", bus.data_out, 16'h0000);
    checkOutput("midreset scan_code", bus.scan_code, 8'h00);
    checkOutput("midreset key_valid", bus.key_valid, 0);
    checkOutput("midreset frame_err", bus.frame_err, 0);
    bus.ps2_data = 1'b1;
    e0 = errPulses;
    rst_n = 1'b1;
    waitCycles(TO + 50);
    checkOutput("post-reset frame_err count", errPulses - e0, 0);
    expQ.push_back(16'h0005);
    applyStimulus(8'h2E, 1'b0, 1'b0, 1'b0, 11);
    checkOutput("post-reset data_out", bus.data_out, 16'h0005);
    checkOutput("post-reset scan_code", bus.scan_code, 8'h2E);

    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_hex_entry.md
Name: ps2_hex_entry

Overview:
- Upstream feeder for the 4-digit seven-segment hex display path.
- Receives PS/2 Set-2 scan codes from the keyboard and decodes hex key presses.
- Maintains the 16-bit four-nibble value driven onto the display decoder's data_in bus.
- Entry is calculator-style: each new digit shifts in from the right, with backspace and clear keys.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronized samples required before the filtered ps2_clk changes level.
- TIMEOUT_CYCLES, 50000: clk cycles without a filtered ps2_clk falling edge mid-frame before the frame is aborted.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- ps2_clk, input, 1: raw keyboard clock, asynchronous to clk.
- ps2_data, input, 1: raw keyboard data, asynchronous to clk.
- data_out, output, 16: hex value; [3:0] is the rightmost, most recent digit; feeds the display decoder's data_in.
- scan_code, output, 8: last correctly received byte.
- key_valid, output, 1: one-cycle pulse when data_out changes due to a key action.
- frame_err, output, 1: one-cycle pulse on a parity, stop-bit or timeout error.

Behaviour:
- Single clock domain; every flop resets asynchronously on rst_n=0.
- Reset values: data_out=16'h0000, scan_code=8'h00, key_valid=0, frame_err=0; all FSM and flags in their idle/clear state.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchronizer.
  - The filtered clock changes only after FILTER_LEN consecutive equal synchronized samples; its reset level is 1.
  - A fall edge is a filtered-clock 1->0 transition, asserted for one cycle.
- Receiver FSM (state advances on fall edges only):
  - IDLE: data=0 on edge -> DATA; data=1 on edge is ignored.
  - DATA: sample 8 bits, LSB first; 3-bit counter; after the 8th bit -> PARITY.
  - PARITY: sample the parity bit -> STOP.
  - STOP: sample the stop bit -> IDLE.
  - Frame is good when the XOR of the 8 data bits and the parity bit is 1 (odd parity) and stop=1.
  - Good frame, stop edge at cycle N: internal code_strobe and scan_code update at N+1.
  - Bad frame: frame_err pulses at N+1, the byte is discarded, and the break/extended flags clear.
  - Timeout: a counter resets on each fall edge and runs while the state is not IDLE. Reaching TIMEOUT_CYCLES forces IDLE and pulses frame_err on the following cycle, so a partial frame never completes.
- Decoder, acting on code_strobe:
  - F0: set brk.
  - E0: set ext.
  - Any other byte: if brk or ext is set, no action and both flags clear. Otherwise act per the key table, then flags stay clear.
  - E0 F0 xx consumes xx with no action.
- Key table (make codes, Set 2): 45=0, 16=1, 1E=2, 26=3, 25=4, 2E=5, 36=6, 3D=7, 3E=8, 46=9, 1C=A, 32=B, 21=C, 23=D, 24=E, 2B=F.
- Key actions:
  - Hex digit: data_out <= {data_out[11:0], nibble}.
  - 66 (backspace): data_out <= {4'h0, data_out[15:4]}.
  - 76 (Esc): data_out <= 16'h0000.
  - Any other code: ignored, no key_valid.
- Timing: data_out updates and key_valid pulses at N+2. Total latency from the stop edge is 2 cycles.
- key_valid pulses on a backspace or clear even when the value is unchanged.
- The 5th and later digits discard the most-significant nibble; no saturation or overflow flag.
- Typematic repeat (repeated make codes without a break) is treated as repeated entry.
- Reset mid-frame aborts immediately. After release the FSM is in IDLE, so a partially received frame is lost and produces no frame_err.

Decomposition:
- Shared header ps2_codes.vh holds:
  - Scan-code constants: CODE_BREAK=F0, CODE_EXT=E0, CODE_BKSP=66, CODE_ESC=76, and the 16 hex make codes.
  - FSM state encodings.
- Sub-module ps2_rx contains the synchronizers, filter, fall-edge detect, receiver FSM and timeout, with outputs code_strobe, code, and err.
- Top level ps2_hex_entry holds the decoder, the flags and the data_out register.

Test Plan:
- Reset then frames 16, 1E, 26, 25 at a 12.5 kHz PS/2 clock -> data_out=1234, four key_valid pulses, each 2 cycles after its stop edge.
- From 1234, frames 1C then F0 1C -> data_out=234A; exactly one key_valid; scan_code=1C after the final frame.
- From 234A, send 66, then E0 71, then 76 -> 0234, then unchanged with no key_valid, then 0000 with key_valid.
- Frame 45 with parity flipped, then a frame with stop=0 -> two frame_err pulses, data_out unchanged, scan_code unchanged.
- 4 bits of a frame then ps2_clk held high for TIMEOUT_CYCLES+10 -> one frame_err pulse; a following good 16 -> data_out shifts in 1.
- Glitches of 3 cycles on ps2_clk during a frame, plus rst_n asserted mid-frame -> glitches produce no extra bits; reset gives all outputs 0 and the next full frame decodes correctly.
